// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, the fetch
// state encoding and a helper that aligns redirect targets.
package if_fetch_unit_pkg;

   localparam int XLEN            = 64;
   localparam int ILEN            = 32;
   localparam int PC_STEP_DEFAULT = 4;

   // Canonical RISC-V NOP (addi x0, x0, 0), kept here for later flush logic.
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      FETCH_IDLE = 3'd0,
      FETCH_REQ  = 3'd1,
      FETCH_WAIT = 3'd2,
      FETCH_DROP = 3'd3,
      FETCH_HOLD = 3'd4
   } fetch_state_e;

   // Instructions are word aligned, so the two low bits of a target are cleared.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
      return {target[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register: redirect load has priority over the sequential
// increment; the increment wraps modulo 2^XLEN.
module if_fetch_unit_pc_reg
   import if_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_en,
   input  logic [XLEN-1:0] load_pc,
   input  logic            inc_en,
   output logic [XLEN-1:0] pc
);

   // PC update: reset value, redirect target, or next sequential address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load_en) begin
         pc <= load_pc;
      end else if (inc_en) begin
         pc <= pc + XLEN'(PC_STEP);
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. Issues one instruction-memory request at a
// time, presents the returned word and its PC toward IF/ID, honours decode
// stalls and redirects, and drops a response that a redirect made stale.
//
// Handshakes: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both high; while valid is high and ready is low the
// address is held unless a redirect replaces it (legal, nothing was accepted).
// Responses carry no ready: each accepted request returns exactly one
// imem_rsp_valid pulse at least one cycle later. The IF/ID side holds
// fetch_valid/Instruction/PCOut until a cycle with id_stall low consumes them.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0,
   parameter int              PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            id_stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_valid,
   output logic [ILEN-1:0] Instruction,
   output logic [XLEN-1:0] PCOut
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirect_target;
   logic            pc_load;
   logic            pc_inc;
   logic            rsp_accept;

   assign redirect_target = align_pc(redirect_pc);

   // A redirect reloads the PC whatever the fetch state is.
   assign pc_load = redirect_valid;

   // A response is kept only when waiting on a live request and no redirect
   // arrives in the same cycle.
   assign rsp_accept = (state == FETCH_WAIT) && imem_rsp_valid && !redirect_valid;
   assign pc_inc     = rsp_accept;

   // Requests come straight from the state and the PC; the address bus is
   // parked at zero whenever no request is offered.
   assign imem_req_valid = (state == FETCH_REQ);
   assign imem_req_addr  = imem_req_valid ? pc : '0;

   if_fetch_unit_pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (pc_load),
      .load_pc (redirect_target),
      .inc_en  (pc_inc),
      .pc      (pc)
   );

   // Fetch sequencer with registered IF/ID outputs; redirect wins over every
   // other event, and a stale response is always swallowed before refetching.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH_IDLE;
         fetch_valid <= 1'b0;
         Instruction <= '0;
         PCOut       <= '0;
      end else begin
         unique case (state)
            FETCH_IDLE: begin
               state <= FETCH_REQ;
            end

            FETCH_REQ: begin
               if (redirect_valid) begin
                  // An accepted request now targets the wrong address.
                  state <= imem_req_ready ? FETCH_DROP : FETCH_REQ;
               end else if (imem_req_ready) begin
                  state <= FETCH_WAIT;
               end
            end

            FETCH_WAIT: begin
               if (redirect_valid) begin
                  // A response arriving together with the redirect is dropped here.
                  state <= imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
               end else if (imem_rsp_valid) begin
                  Instruction <= imem_rsp_data;
                  PCOut       <= pc;
                  fetch_valid <= 1'b1;
                  state       <= FETCH_HOLD;
               end
            end

            FETCH_DROP: begin
               // The one outstanding response is stale no matter what else happens.
               if (imem_rsp_valid) begin
                  state <= FETCH_REQ;
               end
            end

            FETCH_HOLD: begin
               if (redirect_valid || !id_stall) begin
                  fetch_valid <= 1'b0;
                  state       <= FETCH_REQ;
               end
            end

            default: begin
               state       <= FETCH_IDLE;
               fetch_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a memory responder with random
// latency/ready, a transaction-level reference model of the fetch front end,
// directed scenarios with literal expectations and a randomized soak.
module tb_if_fetch_unit;

   localparam logic [63:0] RESET_PC = 64'h0;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        id_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        fetch_valid;
   logic [31:0] Instruction;
   logic [63:0] PCOut;

   if_fetch_unit #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_stall       (id_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_valid    (fetch_valid),
      .Instruction    (Instruction),
      .PCOut          (PCOut)
   );

   // ---------------- bookkeeping ----------------
   int total = 0;
   int bad   = 0;
   int cycle = 0;

   // memory responder: due cycle and data of pending responses
   int          rsp_due_q[$];
   logic [31:0] rsp_data_q[$];

   // observed traffic
   logic [63:0] req_log[$];
   logic [63:0] fetch_pc_log[$];
   logic [31:0] fetch_ins_log[$];
   logic        prev_fv = 1'b0;

   // stimulus knobs
   int          lat_min = 1, lat_max = 1, ready_pct = 100;
   int          stall_mode = 0, stall_pct = 0, redir_pct = 0;
   bit          one_redir = 1'b0;
   logic [63:0] one_redir_pc = 64'h0;

   // reference model: next fetch address, whether a request is in flight
   // (and whether a redirect made it stale), and the presented instruction
   bit          m_started, m_inflight, m_stale, m_out_valid;
   logic [63:0] m_pc, m_req_addr, m_out_pc;
   logic [31:0] m_out_ins;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cycle);
      end
   endtask

   task automatic model_reset();
      m_started   = 1'b0;
      m_inflight  = 1'b0;
      m_stale     = 1'b0;
      m_out_valid = 1'b0;
      m_pc        = RESET_PC;
      m_req_addr  = 64'h0;
      m_out_pc    = 64'h0;
      m_out_ins   = 32'h0;
      prev_fv     = 1'b0;
   endtask

   // ---------------- one clock cycle: compare, drive, advance model ----------------
   task automatic step();
      logic        exp_rv, rdy, rv, redir, stall, fire;
      logic [63:0] exp_ra, rpc;
      logic [31:0] rdata;
      int          lat;
      @(negedge clk);
      // compare
      exp_rv = rst_n && m_started && !m_inflight && !m_out_valid;
      exp_ra = exp_rv ? m_pc : 64'h0;
      chk("req_valid", imem_req_valid, exp_rv);
      chk("req_addr", imem_req_addr, exp_ra);
      chk("fetch_valid", fetch_valid, m_out_valid);
      if (m_out_valid) begin
         chk("instruction", Instruction, m_out_ins);
         chk("pc_out", PCOut, m_out_pc);
         chk("instr_vs_mem", Instruction, mem_word(m_out_pc));
      end
      if (fetch_valid && !prev_fv) begin
         fetch_pc_log.push_back(PCOut);
         fetch_ins_log.push_back(Instruction);
      end
      prev_fv = fetch_valid;
      // choose inputs
      redir = one_redir || ($urandom_range(99) < redir_pct);
      rpc   = one_redir ? one_redir_pc : {$urandom, $urandom};
      one_redir = 1'b0;
      stall = (stall_mode == 1) || ((stall_mode == 2) && ($urandom_range(99) < stall_pct));
      rv    = 1'b0;
      rdata = $urandom;
      if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cycle) begin
         rv = 1'b1;
         void'(rsp_due_q.pop_front());
         rdata = rsp_data_q.pop_front();
      end
      rdy = (rsp_due_q.size() == 0) && ($urandom_range(99) < ready_pct);
      imem_req_ready = rdy;
      imem_rsp_valid = rv;
      imem_rsp_data  = rdata;
      id_stall       = stall;
      redirect_valid = redir;
      redirect_pc    = rpc;
      // memory accepts whatever the DUT actually offers
      if (imem_req_valid && rdy) begin
         lat = $urandom_range(lat_max, lat_min);
         rsp_due_q.push_back(cycle + lat);
         rsp_data_q.push_back(mem_word(imem_req_addr));
         req_log.push_back(imem_req_addr);
      end
      // advance model
      if (rst_n) begin
         fire = exp_rv && rdy;
         if (!m_started) begin
            m_started = 1'b1;
            if (redir) m_pc = {rpc[63:2], 2'b00};
         end else if (redir) begin
            m_pc        = {rpc[63:2], 2'b00};
            m_out_valid = 1'b0;
            if (m_inflight) begin
               if (rv) m_inflight = 1'b0;
               else    m_stale    = 1'b1;
            end
            if (fire) begin
               m_inflight = 1'b1;
               m_stale    = 1'b1;
            end
         end else if (fire) begin
            m_inflight = 1'b1;
            m_stale    = 1'b0;
            m_req_addr = m_pc;
         end else if (rv && m_inflight) begin
            m_inflight = 1'b0;
            if (!m_stale) begin
               m_out_valid = 1'b1;
               m_out_ins   = rdata;
               m_out_pc    = m_req_addr;
               m_pc        = m_req_addr + 64'd4;
            end
         end else if (m_out_valid && !stall) begin
            m_out_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic run_until_req(input int n);
      int k = 0;
      while (req_log.size() < n && k < 80) begin
         step();
         k++;
      end
      chk("req_count_reached", req_log.size() >= n, 1'b1);
   endtask

   task automatic run_until_fetch(input int n);
      int k = 0;
      while (fetch_pc_log.size() < n && k < 80) begin
         step();
         k++;
      end
      chk("fetch_count_reached", fetch_pc_log.size() >= n, 1'b1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- scenarios ----------------
   initial begin
      int n_r, n_f;
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      chk("rst_fetch_valid", fetch_valid, 1'b0);
      chk("rst_instruction", Instruction, 32'h0);
      chk("rst_pc_out", PCOut, 64'h0);
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_req_addr", imem_req_addr, 64'h0);
      step();
      step();
      rst_n = 1'b1;

      // sequential fetch, latency 1, no stall
      lat_min = 1; lat_max = 1; ready_pct = 100; stall_mode = 0;
      run_until_req(3);
      chk("seq_req0", req_log[0], 64'h0);
      chk("seq_req1", req_log[1], 64'h4);
      chk("seq_req2", req_log[2], 64'h8);

      // stall while PC 0x8 is presented
      stall_mode = 1;
      run_until_fetch(3);
      chk("seq_pc0", fetch_pc_log[0], 64'h0);
      chk("seq_pc1", fetch_pc_log[1], 64'h4);
      chk("seq_pc2", fetch_pc_log[2], 64'h8);
      chk("seq_ins0", fetch_ins_log[0], 32'h1357_9BDF);
      chk("seq_ins1", fetch_ins_log[1], 32'h1357_9BDB);
      chk("seq_ins2", fetch_ins_log[2], 32'h1357_9BD7);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_fv", fetch_valid, 1'b1);
         chk("hold_pc", PCOut, 64'h8);
         chk("hold_ins", Instruction, 32'h1357_9BD7);
         chk("hold_no_req", imem_req_valid, 1'b0);
      end
      chk("hold_req_count", req_log.size(), 3);
      stall_mode = 0;
      run_until_req(4);
      chk("after_stall_req", req_log[3], 64'hC);

      // redirect while waiting on a latency-3 response
      lat_min = 3; lat_max = 3;
      run_until_req(req_log.size() + 1);
      n_r = req_log.size();
      n_f = fetch_pc_log.size();
      one_redir = 1'b1; one_redir_pc = 64'h100;
      step();
      run_until_req(n_r + 1);
      chk("redir_wait_req", req_log[n_r], 64'h100);
      run_until_fetch(n_f + 1);
      chk("redir_wait_pc", fetch_pc_log[n_f], 64'h100);
      chk("redir_wait_ins", fetch_ins_log[n_f], 32'h1357_9ADF);

      // redirect while held under stall, unaligned target
      lat_min = 1; lat_max = 1; stall_mode = 1;
      run_until_fetch(fetch_pc_log.size() + 1);
      step();
      step();
      n_r = req_log.size();
      one_redir = 1'b1; one_redir_pc = 64'h203;
      step();
      chk("redir_hold_flush", fetch_valid, 1'b0);
      stall_mode = 0;
      run_until_req(n_r + 1);
      chk("redir_hold_req", req_log[n_r], 64'h200);

      // wrap at the top of the address space
      stall_mode = 1;
      run_until_fetch(fetch_pc_log.size() + 1);
      n_r = req_log.size();
      n_f = fetch_pc_log.size();
      one_redir = 1'b1; one_redir_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      stall_mode = 0;
      run_until_req(n_r + 2);
      chk("wrap_req_top", req_log[n_r], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_req_zero", req_log[n_r + 1], 64'h0);
      run_until_fetch(n_f + 2);
      chk("wrap_pc_top", fetch_pc_log[n_f], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_ins_top", fetch_ins_log[n_f], 32'h1357_9BDC);
      chk("wrap_pc_zero", fetch_pc_log[n_f + 1], 64'h0);

      // asynchronous reset while a latency-3 response is outstanding
      lat_min = 3; lat_max = 3;
      run_until_req(req_log.size() + 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_fetch_valid", fetch_valid, 1'b0);
      chk("async_instruction", Instruction, 32'h0);
      chk("async_pc_out", PCOut, 64'h0);
      chk("async_req_valid", imem_req_valid, 1'b0);
      chk("async_req_addr", imem_req_addr, 64'h0);
      model_reset();
      step();
      rst_n = 1'b1;
      lat_min = 1; lat_max = 1;
      n_r = req_log.size();
      n_f = fetch_pc_log.size();
      run_until_req(n_r + 1);
      chk("post_rst_req", req_log[n_r], RESET_PC);
      run_until_fetch(n_f + 1);
      chk("post_rst_pc", fetch_pc_log[n_f], 64'h0);
      chk("post_rst_ins", fetch_ins_log[n_f], 32'h1357_9BDF);

      // randomized soak against the reference model
      lat_min = 1; lat_max = 4; ready_pct = 70;
      stall_mode = 2; stall_pct = 30; redir_pct = 6;
      for (int i = 0; i < 1200; i++) step();
      redir_pct = 0; stall_mode = 0;
      for (int i = 0; i < 20; i++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
